// File: rtl/airlock_pkg.sv
// Shared types and constants for the two-door airlock sequencer.
// REVERT only exists when AIRLOCK_ABORT_EN is defined.
package airlock_pkg;

  localparam int TIMER_W = 4;
  localparam int DEF_DEPRESS_CYC = 8;
  localparam int DEF_PRESS_CYC = 8;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    OPEN_OUTER,
    FILL,
    OPEN_INNER,
    DONE
`ifdef AIRLOCK_ABORT_EN
    , REVERT
`endif
  } state_t;

  typedef struct packed {
    logic inner_door;
    logic outer_door;
    logic pump_in;
    logic pump_out;
    logic busy;
    logic done;
  } outs_t;

  function automatic outs_t decode(state_t s);
    outs_t o;
    o = '0;
    o.busy = (s != IDLE);
    case (s)
      DRAIN:      o.pump_out = 1'b1;
      FILL:       o.pump_in = 1'b1;
      OPEN_OUTER: o.outer_door = 1'b1;
      OPEN_INNER: o.inner_door = 1'b1;
      DONE:       o.done = 1'b1;
`ifdef AIRLOCK_ABORT_EN
      REVERT:     o.pump_in = 1'b1;
`endif
      default:    o.busy = o.busy;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/airlock_timer.sv
// Pump-phase down-counter: loads N-1, counts to 0 and holds there.
module airlock_timer
  import airlock_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  assign zero = (count == '0);

  always_ff @(posedge Clock) begin
    if (!Reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (!zero)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/airlock_controller.sv
// Airlock sequencer: arbitrates arrive/depart, drives doors and pumps.
// Optional abort/REVERT path is enabled by AIRLOCK_ABORT_EN.
module airlock_controller
  import airlock_pkg::*;
#(
  parameter int DEPRESS_CYC = DEF_DEPRESS_CYC,
  parameter int PRESS_CYC = DEF_PRESS_CYC
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               arrive,
  input  logic               depart,
  input  logic               door_clear,
`ifdef AIRLOCK_ABORT_EN
  input  logic               abort,
`endif
  output logic               inner_door,
  output logic               outer_door,
  output logic               pump_in,
  output logic               pump_out,
  output logic               busy,
  output logic               done,
  output logic [TIMER_W-1:0] timer_count
);

  localparam logic [TIMER_W-1:0] DEP_LD = TIMER_W'(DEPRESS_CYC - 1);
  localparam logic [TIMER_W-1:0] PRS_LD = TIMER_W'(PRESS_CYC - 1);

  state_t state, nxt;
  outs_t  outs;
  logic   chamber_hi, pend_arr, pend_dep, dir_arr;
  logic   serve_arr, serve_dep;
  logic   load, zero;
  logic [TIMER_W-1:0] load_val;

  always_comb begin
    nxt = state;
    serve_arr = 1'b0;
    serve_dep = 1'b0;
    unique case (state)
      IDLE: begin
        // prefer the request that needs no pump run
        if (pend_dep && (chamber_hi || !pend_arr)) begin
          serve_dep = 1'b1;
          nxt = chamber_hi ? OPEN_INNER : FILL;
        end else if (pend_arr) begin
          serve_arr = 1'b1;
          nxt = chamber_hi ? DRAIN : OPEN_OUTER;
        end
      end
      DRAIN:      if (zero) nxt = OPEN_OUTER;
      FILL:       if (zero) nxt = OPEN_INNER;
      OPEN_OUTER: if (door_clear) nxt = dir_arr ? FILL : DONE;
      OPEN_INNER: if (door_clear) nxt = dir_arr ? DONE : DRAIN;
      DONE:       nxt = IDLE;
`ifdef AIRLOCK_ABORT_EN
      REVERT:     if (zero) nxt = IDLE;
`endif
      default:    nxt = IDLE;
    endcase
`ifdef AIRLOCK_ABORT_EN
    if (abort && (state == DRAIN || state == FILL))
      nxt = REVERT;
`endif
  end

  assign load = (nxt != state) && (nxt == DRAIN || nxt == FILL
`ifdef AIRLOCK_ABORT_EN
                || nxt == REVERT
`endif
                );
  assign load_val = (nxt == DRAIN) ? DEP_LD : PRS_LD;

  airlock_timer u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (load),
    .load_val (load_val),
    .count    (timer_count),
    .zero     (zero)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      outs <= '0;
      chamber_hi <= 1'b1;
      pend_arr <= 1'b0;
      pend_dep <= 1'b0;
      dir_arr <= 1'b0;
    end else begin
      state <= nxt;
      outs <= decode(nxt);
      pend_arr <= (pend_arr | arrive) & ~serve_arr;
      pend_dep <= (pend_dep | depart) & ~serve_dep;
      if (serve_arr)
        dir_arr <= 1'b1;
      else if (serve_dep)
        dir_arr <= 1'b0;
      if (state == DRAIN && nxt == OPEN_OUTER)
        chamber_hi <= 1'b0;
      if (state == FILL && nxt == OPEN_INNER)
        chamber_hi <= 1'b1;
`ifdef AIRLOCK_ABORT_EN
      if (state == REVERT && nxt == IDLE) begin
        chamber_hi <= 1'b1;
        pend_arr <= 1'b0;
        pend_dep <= 1'b0;
      end
`endif
    end
  end

  assign inner_door = outs.inner_door;
  assign outer_door = outs.outer_door;
  assign pump_in = outs.pump_in;
  assign pump_out = outs.pump_out;
  assign busy = outs.busy;
  assign done = outs.done;

endmodule

// File: tb/tb_airlock_controller.sv
// Directed bench for airlock_controller (default 8/8 and 1/15 cycle builds).
// Abort scenario runs only when AIRLOCK_ABORT_EN is defined.
module tb_airlock_controller;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic arrive = 1'b0;
  logic depart = 1'b0;
  logic door_clear = 1'b0;
`ifdef AIRLOCK_ABORT_EN
  logic abort = 1'b0;
`endif

  logic in1, out1, pi1, po1, b1, d1;
  logic in2, out2, pi2, po2, b2, d2;
  logic [3:0] t1, t2;

  int vecs = 0;
  int errs = 0;

  always #5 Clock = ~Clock;

  airlock_controller dut1 (
    .Clock       (Clock),
    .Reset       (Reset),
    .arrive      (arrive),
    .depart      (depart),
    .door_clear  (door_clear),
`ifdef AIRLOCK_ABORT_EN
    .abort       (abort),
`endif
    .inner_door  (in1),
    .outer_door  (out1),
    .pump_in     (pi1),
    .pump_out    (po1),
    .busy        (b1),
    .done        (d1),
    .timer_count (t1)
  );

  airlock_controller #(.DEPRESS_CYC(1), .PRESS_CYC(15)) dut2 (
    .Clock       (Clock),
    .Reset       (Reset),
    .arrive      (arrive),
    .depart      (depart),
    .door_clear  (door_clear),
`ifdef AIRLOCK_ABORT_EN
    .abort       (abort),
`endif
    .inner_door  (in2),
    .outer_door  (out2),
    .pump_in     (pi2),
    .pump_out    (po2),
    .busy        (b2),
    .done        (d2),
    .timer_count (t2)
  );

  // {inner, outer, pump_in, pump_out, busy, done, timer_count}
  wire [9:0] ob1 = {in1, out1, pi1, po1, b1, d1, t1};
  wire [9:0] ob2 = {in2, out2, pi2, po2, b2, d2, t2};

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_pump(input bit w, input bit fill, input int first,
                         input int n, input string nm);
    logic [9:0] exp, obs;
    for (int i = 0; i < n; i++) begin
      exp = {2'b00, fill, ~fill, 2'b10, 4'(first - i)};
      obs = w ? ob2 : ob1;
      vecs++;
      if (obs !== exp) begin
        $display("FAIL %s c%0d: got %b want %b", nm, i, obs, exp);
        errs++;
      end
      tick();
    end
  endtask

  task automatic do_open(input bit w, input bit inner, input int hold,
                         input string nm);
    logic [9:0] exp, obs;
    exp = {inner, ~inner, 4'b0010, 4'h0};
    for (int i = 0; i <= hold; i++) begin
      door_clear = (i == hold);
      obs = w ? ob2 : ob1;
      vecs++;
      if (obs !== exp) begin
        $display("FAIL %s c%0d: got %b want %b", nm, i, obs, exp);
        errs++;
      end
      tick();
    end
    door_clear = 1'b0;
  endtask

  task automatic do_done(input bit w, input string nm);
    logic [9:0] obs;
    obs = w ? ob2 : ob1;
    vecs++;
    if (obs !== 10'b0000110000) begin
      $display("FAIL %s done: got %b want 0000110000", nm, obs);
      errs++;
    end
    tick();
    obs = w ? ob2 : ob1;
    vecs++;
    if (obs !== 10'b0) begin
      $display("FAIL %s idle: got %b want 0000000000", nm, obs);
      errs++;
    end
    tick();
  endtask

  task automatic request(input bit w, input bit a, input bit d,
                         input string nm);
    logic [9:0] obs;
    arrive = a;
    depart = d;
    tick();
    arrive = 1'b0;
    depart = 1'b0;
    obs = w ? ob2 : ob1;
    vecs++;
    if (obs !== 10'b0) begin
      $display("FAIL %s latch: got %b want 0000000000", nm, obs);
      errs++;
    end
    tick();
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    vecs++;
    if ({ob1, ob2} !== 20'b0) begin
      $display("FAIL rst_hold: got %b want 0", {ob1, ob2});
      errs++;
    end
    Reset = 1'b1;
    tick();
    vecs++;
    if ({ob1, ob2} !== 20'b0) begin
      $display("FAIL rst_rel: got %b want 0", {ob1, ob2});
      errs++;
    end
  endtask

  task automatic test_arrive();
    request(0, 1, 0, "arr");
    do_pump(0, 0, 7, 8, "arr_drain");
    do_open(0, 0, 3, "arr_outer");
    do_pump(0, 1, 7, 8, "arr_fill");
    do_open(0, 1, 3, "arr_inner");
    do_done(0, "arr");
  endtask

  task automatic test_depart();
    do_reset();
    request(0, 0, 1, "dep");
    do_open(0, 1, 3, "dep_inner");
    do_pump(0, 0, 7, 8, "dep_drain");
    do_open(0, 0, 3, "dep_outer");
    do_done(0, "dep");
    request(0, 1, 0, "arr2");
    do_open(0, 0, 2, "arr2_outer");
    do_pump(0, 1, 7, 8, "arr2_fill");
    do_open(0, 1, 1, "arr2_inner");
    do_done(0, "arr2");
  endtask

  task automatic test_both();
    request(0, 1, 1, "both");
    do_open(0, 1, 1, "both_dep_inner");
    do_pump(0, 0, 7, 8, "both_dep_drain");
    do_open(0, 0, 1, "both_dep_outer");
    do_done(0, "both_dep");
    do_open(0, 0, 1, "both_arr_outer");
    do_pump(0, 1, 7, 8, "both_arr_fill");
    do_open(0, 1, 1, "both_arr_inner");
    do_done(0, "both_arr");
  endtask

  task automatic test_late_pulse();
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    depart = 1'b1;
    vecs++;
    if (ob1 !== 10'b0) begin
      $display("FAIL late_latch: got %b want 0000000000", ob1);
      errs++;
    end
    tick();
    depart = 1'b0;
    do_pump(0, 0, 7, 8, "late_drain");
    do_open(0, 0, 0, "late_outer");
    do_pump(0, 1, 7, 8, "late_fill");
    do_open(0, 1, 0, "late_inner");
    do_done(0, "late_arr");
    do_open(0, 1, 0, "late_dep_inner");
    do_pump(0, 0, 7, 8, "late_dep_drain");
    do_open(0, 0, 0, "late_dep_outer");
    do_done(0, "late_dep");
  endtask

  task automatic test_reset_mid_fill();
    request(0, 1, 0, "mid");
    do_open(0, 0, 0, "mid_outer");
    do_pump(0, 1, 7, 3, "mid_fill");
    depart = 1'b1;
    tick();
    depart = 1'b0;
    Reset = 1'b0;
    tick();
    vecs++;
    if (ob1 !== 10'b0) begin
      $display("FAIL mid_rst: got %b want 0000000000", ob1);
      errs++;
    end
    Reset = 1'b1;
    tick();
    tick();
    vecs++;
    if (ob1 !== 10'b0) begin
      $display("FAIL mid_pend: got %b want 0000000000", ob1);
      errs++;
    end
    request(0, 0, 1, "mid_dep");
    do_open(0, 1, 0, "mid_dep_inner");
    do_pump(0, 0, 7, 8, "mid_dep_drain");
    do_open(0, 0, 0, "mid_dep_outer");
    do_done(0, "mid_dep");
  endtask

  task automatic test_cycles();
    do_reset();
    request(1, 1, 0, "cyc");
    do_pump(1, 0, 0, 1, "cyc_drain1");
    do_open(1, 0, 0, "cyc_outer");
    do_pump(1, 1, 14, 15, "cyc_fill15");
    do_open(1, 1, 0, "cyc_inner");
    do_done(1, "cyc");
  endtask

`ifdef AIRLOCK_ABORT_EN
  task automatic test_abort();
    do_reset();
    request(0, 1, 0, "abt");
    do_pump(0, 0, 7, 3, "abt_drain");
    abort = 1'b1;
    do_pump(0, 0, 4, 1, "abt_drain4");
    abort = 1'b0;
    do_pump(0, 1, 7, 8, "abt_revert");
    vecs++;
    if (ob1 !== 10'b0) begin
      $display("FAIL abt_idle: got %b want 0000000000", ob1);
      errs++;
    end
    request(0, 1, 0, "abt2");
    do_pump(0, 0, 7, 8, "abt2_drain");
    abort = 1'b1;
    do_open(0, 0, 2, "abt2_outer");
    abort = 1'b0;
    do_pump(0, 1, 7, 8, "abt2_fill");
    do_open(0, 1, 0, "abt2_inner");
    do_done(0, "abt2");
  endtask
`endif

  initial begin
    test_reset();
    test_arrive();
    test_depart();
    test_both();
    test_late_pulse();
    test_reset_mid_fill();
    test_cycles();
`ifdef AIRLOCK_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
